// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: run state encoding and duty/counter widths.
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel of the PWM ramp controller: run request plus the valid/ready duty handshake.
interface pwm_ramp_ctrl_if;
    import pwm_pkg::*;

    logic              enable;
    logic              cmd_valid;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_ready;

    modport master (output enable, output cmd_valid, output cmd_duty, input cmd_ready);
    modport slave  (input enable, input cmd_valid, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/pwm_core.sv
// Prescaler, 8-bit PWM counter and registered comparator; boundary marks the tick on which
// the counter wraps from 255, i.e. the last cycle of a PWM period.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 2048
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm,
    output logic              boundary
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   ps_q, ps_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              pwm_q, pwm_d;
    logic              tick;

    // Everything collapses to zero whenever the controller is not running.
    always_comb begin
        tick  = (ps_q == PS_MAX);
        ps_d  = '0;
        cnt_d = '0;
        pwm_d = 1'b0;
        if (enable) begin
            ps_d  = tick ? '0 : ps_q + 1'b1;
            cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
            pwm_d = (cnt_q < duty);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_q  <= '0;
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            ps_q  <= ps_d;
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm      = pwm_q;
    assign boundary = tick && (cnt_q == CNT_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM controller with a one-deep command slot and duty changes applied only at period boundaries.
// Define PWM_RAMP_EN to limit each boundary change to STEP; otherwise the target loads directly.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 2048,
    parameter int STEP     = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    pwm_ramp_ctrl_if.slave    cmd,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              busy,
    output logic              period_start
);

`ifdef PWM_RAMP_EN
    localparam int STEP_LIM = STEP;
`else
    // A limit above any possible gap makes every boundary load the target outright.
    localparam int STEP_LIM = (1 << DUTY_W) + 0 * STEP;
`endif

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [DUTY_W-1:0] pend_val_q, pend_val_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              core_en;
    logic              boundary;
    logic              cmd_ready;

    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] gap;
        logic [DUTY_W:0] lim;
        lim = (DUTY_W + 1)'(STEP_LIM);
        if (tgt >= cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            if (gap > lim) gap = lim;
            step_toward = cur + gap[DUTY_W-1:0];
        end else begin
            gap = {1'b0, cur} - {1'b0, tgt};
            if (gap > lim) gap = lim;
            step_toward = cur - gap[DUTY_W-1:0];
        end
    endfunction

    assign core_en   = (state_q == RUN) && cmd.enable;
    assign cmd_ready = (state_q == RUN) && !pend_q;

    pwm_core #(
        .PRESCALE (PRESCALE)
    ) u_core (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enable   (core_en),
        .duty     (duty_q),
        .pwm      (pwm_out),
        .boundary (boundary)
    );

    // A command accepted on a boundary lands in the slot after the slot was drained,
    // so it waits a full period before it reaches the target.
    always_comb begin
        state_d    = cmd.enable ? RUN : IDLE;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        target_d   = target_q;
        duty_d     = duty_q;
        if (!cmd.enable) begin
            pend_d     = 1'b0;
            pend_val_d = '0;
            target_d   = '0;
            duty_d     = '0;
        end else if (state_q == RUN) begin
            if (boundary) begin
                if (pend_q) begin
                    target_d = pend_val_q;
                    pend_d   = 1'b0;
                end
                duty_d = step_toward(duty_q, target_d);
            end
            if (cmd.cmd_valid && cmd_ready) begin
                pend_d     = 1'b1;
                pend_val_d = cmd.cmd_duty;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            target_q   <= '0;
            duty_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            target_q   <= target_d;
            duty_q     <= duty_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready;
    assign duty_cur      = duty_q;
    assign busy          = pend_q || (duty_q != target_q);
    assign period_start  = (state_q == RUN) && boundary;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl (PRESCALE=4, STEP=16): directed scenarios plus random traffic, every
// cycle compared against a reference model built on elapsed run time; honours PWM_RAMP_EN.
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int P      = 4;
    localparam int STEP   = 16;
    localparam int PERIOD = 256 * P;
`ifdef PWM_RAMP_EN
    localparam int STEP_EFF = STEP;
`else
    localparam int STEP_EFF = 256;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              pwm_out;
    logic [DUTY_W-1:0] duty_cur;
    logic              busy;
    logic              period_start;

    pwm_ramp_ctrl_if cmd_if ();

    pwm_ramp_ctrl #(
        .PRESCALE (P),
        .STEP     (STEP)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cmd          (cmd_if),
        .pwm_out      (pwm_out),
        .duty_cur     (duty_cur),
        .busy         (busy),
        .period_start (period_start)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: m_n counts cycles since the controller entered RUN.
    bit m_run;
    int m_n;
    bit m_pend;
    int m_pval;
    int m_tgt;
    int m_duty;
    bit m_pwm;
    bit m_accept;

    function automatic bit m_bnd(input int n);
        return (n % PERIOD) == (PERIOD - 1);
    endfunction

    function automatic bit m_busy();
        return m_pend || (m_duty != m_tgt);
    endfunction

    task automatic modelClear();
        m_run = 0; m_n = 0; m_pend = 0; m_pval = 0; m_tgt = 0; m_duty = 0; m_pwm = 0; m_accept = 0;
    endtask

    task automatic modelEdge(input bit en, input bit v, input int d);
        int delta;
        m_accept = 0;
        if (!en) begin
            modelClear();
        end else if (!m_run) begin
            m_run = 1; m_n = 0; m_pwm = 0;
        end else begin
            m_pwm    = (((m_n / P) % 256) < m_duty);
            m_accept = v && !m_pend;
            if (m_bnd(m_n)) begin
                if (m_pend) begin
                    m_tgt  = m_pval;
                    m_pend = 0;
                end
                delta = m_tgt - m_duty;
                if (delta > STEP_EFF)  delta = STEP_EFF;
                if (delta < -STEP_EFF) delta = -STEP_EFF;
                m_duty = m_duty + delta;
            end
            if (m_accept) begin
                m_pend = 1;
                m_pval = d;
            end
            m_n++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("pwm_out", pwm_out, m_pwm);
        checkOutput("duty_cur", duty_cur, m_duty);
        checkOutput("busy", busy, m_busy());
        checkOutput("cmd_ready", cmd_if.cmd_ready, m_run && !m_pend);
        checkOutput("period_start", period_start, m_run && m_bnd(m_n));
    endtask

    task automatic applyStimulus(input bit en, input bit v, input int d);
        logic [31:0] dv;
        dv = d;
        cmd_if.enable    = en;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_duty  = dv[DUTY_W-1:0];
        @(posedge CLK);
        #1;
        modelEdge(en, v, d);
        checkAll();
    endtask

    task automatic runIdle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1, 0, $urandom_range(0, 255));
    endtask

    task automatic runToPhase(input int ph);
        int guard = 0;
        bit to;
        while ((m_n % PERIOD) != ph && guard < 2 * PERIOD) begin
            applyStimulus(1, 0, $urandom_range(0, 255));
            guard++;
        end
        to = (guard >= 2 * PERIOD);
        checkOutput("phase_timeout", to, 0);
    endtask

    task automatic settle();
        int guard = 0;
        bit to;
        while (m_busy() && guard < 20 * PERIOD) begin
            applyStimulus(1, 0, $urandom_range(0, 255));
            guard++;
        end
        to = (guard >= 20 * PERIOD);
        checkOutput("settle_timeout", to, 0);
    endtask

    task automatic sendCmd(input int d);
        int guard = 0;
        bit to;
        do begin
            applyStimulus(1, 1, d);
            guard++;
        end while (!m_accept && guard < 2 * PERIOD);
        to = !m_accept;
        checkOutput("accept_timeout", to, 0);
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        #2;
        modelClear();
        checkAll();
        @(posedge CLK);
        #1;
        checkAll();
        #2;
        RST_N = 1'b1;
    endtask

    // Count cycles with pwm_out at the given level across one full period after a boundary.
    task automatic measureLevel(input bit level, output int count);
        runToPhase(PERIOD - 1);
        count = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1, 0, $urandom_range(0, 255));
            if (pwm_out === level) count++;
        end
    endtask

    initial begin
        int cnt;
        int peak;
        int exp_duty;

        RST_N            = 1'b0;
        cmd_if.enable    = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_duty  = '0;
        modelClear();
        repeat (2) @(posedge CLK);
        #1;
        checkAll();
        #2;
        RST_N = 1'b1;

        $display("[TB] enable with no command");
        runIdle(PERIOD + 20);
        checkOutput("idle_run_duty", duty_cur, 0);

        $display("[TB] command 64");
        sendCmd(64);
        settle();
        checkOutput("duty_64", duty_cur, 64);
        measureLevel(1'b1, cnt);
        checkOutput("high_time_64", cnt, 64 * P);

        $display("[TB] back-to-back commands 200 then 10");
        runIdle($urandom_range(1, 300));
        sendCmd(200);
        checkOutput("ready_after_first", cmd_if.cmd_ready, 0);
        peak = 0;
        sendCmd(10);
        for (int i = 0; i < 20 * PERIOD && m_busy(); i++) begin
            applyStimulus(1, 0, $urandom_range(0, 255));
            if (int'(duty_cur) > peak) peak = duty_cur;
        end
        checkOutput("no_overshoot", (peak <= 200), 1);
        checkOutput("final_duty_10", duty_cur, 10);

        $display("[TB] command one cycle before a boundary");
        runToPhase(PERIOD - 2);
        applyStimulus(1, 1, 128);
        applyStimulus(1, 0, 0);
        exp_duty = 10 + ((STEP_EFF < 118) ? STEP_EFF : 118);
        checkOutput("cmd_before_boundary", duty_cur, exp_duty);
        settle();

        $display("[TB] command on a boundary cycle");
        runToPhase(PERIOD - 1);
        applyStimulus(1, 1, 40);
        checkOutput("cmd_on_boundary_hold", duty_cur, 128);
        checkOutput("cmd_on_boundary_busy", busy, 1);
        runToPhase(PERIOD - 1);
        applyStimulus(1, 0, 0);
        exp_duty = 128 - ((STEP_EFF < 88) ? STEP_EFF : 88);
        checkOutput("cmd_on_boundary_apply", duty_cur, exp_duty);
        settle();

        $display("[TB] enable dropped mid-ramp");
        sendCmd(250);
        runIdle(2 * PERIOD + 100);
        applyStimulus(0, 0, 0);
        checkOutput("en_drop_duty", duty_cur, 0);
        checkOutput("en_drop_pwm", pwm_out, 0);
        checkOutput("en_drop_ready", cmd_if.cmd_ready, 0);
        applyStimulus(0, 1, 77);
        applyStimulus(1, 0, 0);
        sendCmd(250);
        runToPhase(PERIOD - 1);
        applyStimulus(1, 0, 0);
        checkOutput("restart_first_step", duty_cur, (STEP_EFF < 250) ? STEP_EFF : 250);

        $display("[TB] reset mid-ramp");
        sendCmd(200);
        runIdle(PERIOD + PERIOD / 2);
        doReset();
        checkOutput("reset_duty", duty_cur, 0);
        runIdle(PERIOD + 10);
        checkOutput("reset_restart_duty", duty_cur, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 8000; i++) begin
            applyStimulus(($urandom_range(0, 1999) != 0), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 255));
        end

        $display("[TB] command 255");
        applyStimulus(1, 0, 0);
        sendCmd(255);
        settle();
        checkOutput("duty_255", duty_cur, 255);
        measureLevel(1'b0, cnt);
        checkOutput("low_time_255", cnt, P);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter PRESCALE, default 2048, is the number of CLK cycles per PWM counter tick (legal range 2..65535).
REQ-002 Parameter STEP, default 1, is the maximum duty change per PWM period (legal range 1..255).
REQ-003 CLK  input  1  system clock; all logic runs on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  run request; low forces the idle state.
REQ-006 cmd_valid  input  1  a new target duty is offered on cmd_duty.
REQ-007 cmd_duty  input  8  target duty in 1/256 units.
REQ-008 cmd_ready  output  1  a command is accepted this cycle when both cmd_valid and cmd_ready are high.
REQ-009 pwm_out  output  1  registered PWM drive.
REQ-010 duty_cur  output  8  duty currently applied to the comparator.
REQ-011 busy  output  1  high while duty_cur differs from the target or a command is pending.
REQ-012 period_start  output  1  one-CLK pulse at each PWM period boundary.

Function
REQ-013 The prescaler shall count 0..PRESCALE-1 and assert an internal tick for one CLK cycle when it wraps.
REQ-014 On each tick the 8-bit PWM counter shall increment modulo 256.
REQ-015 A period boundary shall be a tick on which the counter holds 255; period_start shall pulse on that cycle.
REQ-016 pwm_out shall be registered as (counter < duty_cur); duty 0 gives constant low and duty 255 gives 255/256 high.
REQ-017 The states shall be IDLE (enable low) and RUN (enable high); IDLE->RUN on enable high and RUN->IDLE on enable low, both on the next CLK edge.
REQ-018 In IDLE the prescaler, counter, duty_cur, target and the pending flag shall be zero, pwm_out shall be 0, cmd_ready shall be 0, and period_start shall be 0.
REQ-019 In RUN, cmd_ready shall equal the inverse of the pending flag; an accepted command shall store cmd_duty and set the pending flag; there shall be no other buffering.
REQ-020 At a period boundary with the pending flag set, target shall load the pending value and the pending flag shall clear on the same edge.
REQ-021 At each period boundary, duty_cur shall move toward the updated target by min(STEP, |target-duty_cur|), with no overshoot and no wrap; the arithmetic is 9-bit.
REQ-022 duty_cur shall change only at period boundaries, so no PWM period is truncated.
REQ-023 If a command is accepted on the same cycle as a boundary, it shall be stored as pending and shall not take effect until the next boundary.
REQ-024 busy shall equal (pending flag) OR (duty_cur != target).

Reset
REQ-025 While RST_N is low, all registers shall take their IDLE values: pwm_out=0, duty_cur=0, busy=0, cmd_ready=0, period_start=0.
REQ-026 Reset asserted mid-ramp shall abort the ramp immediately; after release, operation shall restart from duty 0.

Configuration
REQ-027 With macro PWM_RAMP_EN defined, duty_cur shall ramp per REQ-021.
REQ-028 Without PWM_RAMP_EN, duty_cur shall load target directly at the boundary (step unlimited) and the STEP parameter shall be ignored.

Structure
REQ-029 The shared package pwm_pkg shall hold the state encoding (IDLE/RUN), the DUTY_W=8 constant and the counter maximum 8'hFF.
REQ-030 The prescaler, counter and comparator shall form sub-module pwm_core (inputs: enable and duty; outputs: pwm and boundary); the state machine, handshake and ramp logic shall stay in pwm_ramp_ctrl.

Verification (PRESCALE=4, STEP=16 unless noted)
REQ-031 Reset, then enable=1 with no command -> pwm_out stays 0, duty_cur=0, busy=0, cmd_ready=1.
REQ-032 Command 64 -> duty_cur reads 16, 32, 48, 64 at four successive boundaries; busy falls with the last step; high time is 64 ticks (256 CLK) of every 1024-CLK period.
REQ-033 Two back-to-back commands (200 then 10) -> cmd_ready drops after the first; the second is accepted only after the next boundary; duty rises toward 200 and then reverses toward 10 without overshoot.
REQ-034 Command on a boundary cycle -> it is applied one period later than a command accepted the cycle before.
REQ-035 enable dropped mid-ramp -> pwm_out=0, duty_cur=0 and cmd_ready=0 on the next cycle; re-enabling restarts from 0.
REQ-036 Build without PWM_RAMP_EN, command 255 -> duty_cur=255 at the first boundary, and pwm_out is low exactly 1 tick per period.
